// File: rtl/rs_ap_ctrl_relay_pipeline.sv
// rs_ap_ctrl_relay_pipeline
//   Relays an ap_ctrl (ap_start/ap_ready) handshake plus its argument
//   payload through LEVEL registered stages. Each stage is a 2-entry
//   in-order buffer whose ready output is a flop. This allows full
//   throughput while breaking the ready path between stages. After reset
//   a grace counter holds off both handshake sides for GRACE_PERIOD cycles.
// Ports:
//   clk        - single clock for all stages
//   reset      - asynchronous reset, active low
//   in_start   - upstream ap_start (valid)
//   in_args    - payload qualified by in_start
//   in_ready   - upstream ap_ready
//   out_start  - ap_start to the kernel
//   out_args   - payload qualified by out_start
//   out_ready  - ap_ready from the kernel
//   inflight   - number of tokens held in the pipeline (0..2*LEVEL)
//   grace_busy - high while the post-reset grace counter is nonzero
module rs_ap_ctrl_relay_pipeline #(
  parameter int unsigned LEVEL        = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GRACE_PERIOD = 2 * LEVEL
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_start,
  input  logic [DATA_WIDTH-1:0]            in_args,
  output logic                             in_ready,
  output logic                             out_start,
  output logic [DATA_WIDTH-1:0]            out_args,
  input  logic                             out_ready,
  output logic [$clog2(2*LEVEL+1)-1:0]     inflight,
  output logic                             grace_busy
);

  localparam int unsigned IW = $clog2(2 * LEVEL + 1);
  localparam int unsigned GW = (GRACE_PERIOD > 0) ? $clog2(GRACE_PERIOD + 1) : 1;
  localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_PERIOD);

  // Per-stage state: occupancy, oldest (head) and second (tail) entries,
  // and the registered ready flag.
  logic [1:0]            cnt_q  [LEVEL];
  logic [1:0]            cnt_d  [LEVEL];
  logic [DATA_WIDTH-1:0] head_q [LEVEL];
  logic [DATA_WIDTH-1:0] head_d [LEVEL];
  logic [DATA_WIDTH-1:0] tail_q [LEVEL];
  logic [DATA_WIDTH-1:0] tail_d [LEVEL];
  logic [LEVEL-1:0]      rdy_q;
  logic [LEVEL-1:0]      rdy_d;
  logic [IW-1:0]         inflight_q;
  logic [IW-1:0]         inflight_d;
  logic [GW-1:0]         grace_q;
  logic [GW-1:0]         grace_d;

  // Inter-stage wiring
  logic [LEVEL-1:0]      stg_valid;
  logic [LEVEL-1:0]      up_valid;
  logic [LEVEL-1:0]      dn_ready;
  logic [DATA_WIDTH-1:0] up_data [LEVEL];
  logic [LEVEL-1:0]      push;
  logic [LEVEL-1:0]      pop;
  logic                  in_hs;
  logic                  out_hs;

  always_comb begin
    grace_busy = (grace_q != '0);

    for (int unsigned i = 0; i < LEVEL; i++) begin
      stg_valid[i] = (cnt_q[i] != 2'd0);
    end

    in_ready  = rdy_q[0] & ~grace_busy;
    out_start = stg_valid[LEVEL-1] & ~grace_busy;
    out_args  = head_q[LEVEL-1];
    inflight  = inflight_q;
    in_hs     = in_start & in_ready;
    out_hs    = out_start & out_ready;

    // Stage 0 is fed by the upstream port, each later stage by its
    // predecessor's head entry; the last stage sees out_ready masked by grace.
    up_valid[0] = in_start & ~grace_busy;
    up_data[0]  = in_args;
    for (int unsigned i = 1; i < LEVEL; i++) begin
      up_valid[i] = stg_valid[i-1];
      up_data[i]  = head_q[i-1];
    end
    dn_ready[LEVEL-1] = out_ready & ~grace_busy;
    for (int unsigned i = 0; i + 1 < LEVEL; i++) begin
      dn_ready[i] = rdy_q[i+1];
    end

    for (int unsigned i = 0; i < LEVEL; i++) begin
      push[i]   = up_valid[i] & rdy_q[i];
      pop[i]    = stg_valid[i] & dn_ready[i];
      cnt_d[i]  = cnt_q[i];
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      unique case ({push[i], pop[i]})
        2'b10: begin
          if (cnt_q[i] == 2'd0) head_d[i] = up_data[i];
          else                  tail_d[i] = up_data[i];
          cnt_d[i] = cnt_q[i] + 2'd1;
        end
        2'b01: begin
          head_d[i] = tail_q[i];
          cnt_d[i]  = cnt_q[i] - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the incoming entry lands behind whatever
          // remains after the head leaves.
          if (cnt_q[i] == 2'd1) begin
            head_d[i] = up_data[i];
          end else begin
            head_d[i] = tail_q[i];
            tail_d[i] = up_data[i];
          end
        end
        default: ;
      endcase
      rdy_d[i] = (cnt_d[i] < 2'd2);
    end

    inflight_d = inflight_q;
    unique case ({in_hs, out_hs})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: ;
    endcase

    grace_d = grace_busy ? grace_q - GW'(1) : grace_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LEVEL; i++) begin
        cnt_q[i]  <= '0;
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
      rdy_q      <= '0;
      inflight_q <= '0;
      grace_q    <= GRACE_INIT;
    end else begin
      for (int unsigned i = 0; i < LEVEL; i++) begin
        cnt_q[i]  <= cnt_d[i];
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
      end
      rdy_q      <= rdy_d;
      inflight_q <= inflight_d;
      grace_q    <= grace_d;
    end
  end

endmodule

// File: tb/tb_rs_ap_ctrl_relay_pipeline.sv
// Testbench for rs_ap_ctrl_relay_pipeline: a LEVEL=6/GRACE_PERIOD=12 instance
// checked against a queue scoreboard, plus a LEVEL=1/GRACE_PERIOD=0 instance.
module tb_rs_ap_ctrl_relay_pipeline;

  localparam int L = 6;
  localparam int G = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_start;
  logic [31:0] in_args;
  logic        in_ready;
  logic        out_start;
  logic [31:0] out_args;
  logic        out_ready;
  logic [3:0]  inflight;
  logic        grace_busy;

  logic        reset1;
  logic        s_start;
  logic [7:0]  s_args;
  logic        s_in_ready;
  logic        s_out_start;
  logic [7:0]  s_out_args;
  logic        s_ready;
  logic [1:0]  s_inflight;
  logic        s_grace;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];
  int          gm = 0;

  always #5 clk = ~clk;

  rs_ap_ctrl_relay_pipeline #(.LEVEL(L), .DATA_WIDTH(32), .GRACE_PERIOD(G)) dut (
    .clk(clk), .reset(reset), .in_start(in_start), .in_args(in_args),
    .in_ready(in_ready), .out_start(out_start), .out_args(out_args),
    .out_ready(out_ready), .inflight(inflight), .grace_busy(grace_busy)
  );

  rs_ap_ctrl_relay_pipeline #(.LEVEL(1), .DATA_WIDTH(8), .GRACE_PERIOD(0)) dut1 (
    .clk(clk), .reset(reset1), .in_start(s_start), .in_args(s_args),
    .in_ready(s_in_ready), .out_start(s_out_start), .out_args(s_out_args),
    .out_ready(s_ready), .inflight(s_inflight), .grace_busy(s_grace)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the main DUT: drive at the negedge, check, update the
  // scoreboard from the handshakes seen, then advance to the next negedge.
  task automatic cycle(input logic s, input logic [31:0] a, input logic r);
    logic ihs;
    logic ohs;
    in_start  = s;
    in_args   = a;
    out_ready = r;
    #1;
    check_eq("inflight", {28'd0, inflight}, sb_q.size());
    check_eq("grace_busy", {31'd0, grace_busy}, {31'd0, gm != 0});
    if (gm != 0) begin
      check_eq("grace_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("grace_out_start", {31'd0, out_start}, 32'd0);
    end
    if (sb_q.size() >= 2 * L) check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
    if (out_start) begin
      if (sb_q.size() == 0) check_eq("stale_out", {31'd0, out_start}, 32'd0);
      else check_eq("out_args", out_args, sb_q[0]);
    end
    ihs = in_start & in_ready;
    ohs = out_start & out_ready;
    if (ohs && sb_q.size() > 0) void'(sb_q.pop_front());
    if (ihs) sb_q.push_back(a);
    @(negedge clk);
    if (gm > 0) gm--;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc;
    reset = 1'b1; reset1 = 1'b1;
    in_start = 1'b0; in_args = '0; out_ready = 1'b0;
    s_start = 1'b0; s_args = '0; s_ready = 1'b0;
    #2;
    reset = 1'b0; reset1 = 1'b0;
    #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_start", {31'd0, out_start}, 32'd0);
    check_eq("rst_out_args", out_args, 32'd0);
    check_eq("rst_inflight", {28'd0, inflight}, 32'd0);
    check_eq("rst_grace_busy", {31'd0, grace_busy}, 32'd1);
    check_eq("rst1_grace_busy", {31'd0, s_grace}, 32'd0);
    check_eq("rst1_in_ready", {31'd0, s_in_ready}, 32'd0);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    gm = G;

    // Grace period with in_start held high
    for (int k = 0; k < G; k++) cycle(1'b1, 32'hA5, 1'b1);
    check_eq("in_ready_after_grace", {31'd0, in_ready}, 32'd1);

    // Single token latency through an empty pipe
    cycle(1'b1, 32'hA5, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      check_eq("lat_out_start", {31'd0, out_start}, {31'd0, j == L});
      if (j == L) check_eq("lat_out_args", out_args, 32'hA5);
      cycle(1'b0, 32'h0, 1'b1);
    end

    // Fill to capacity under backpressure
    for (int k = 0; k < 20; k++) cycle(1'b1, 32'h100 + k, 1'b0);
    check_eq("fill_count", sb_q.size(), 2 * L);
    check_eq("fill_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("fill_inflight", {28'd0, inflight}, 2 * L);

    // Drain: 12 tokens on 12 consecutive cycles in order
    for (int k = 0; k < 2 * L; k++) begin
      check_eq("drain_start", {31'd0, out_start}, 32'd1);
      check_eq("drain_args", out_args, 32'h100 + k);
      cycle(1'b0, 32'h0, 1'b1);
    end
    check_eq("drain_inflight", {28'd0, inflight}, 32'd0);

    // Continuous streaming
    for (int k = 0; k < 30; k++) begin
      if (k >= L) begin
        check_eq("stream_start", {31'd0, out_start}, 32'd1);
        check_eq("stream_inflight", {28'd0, inflight}, L);
      end
      cycle(1'b1, 32'h200 + k, 1'b1);
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 1'b1);
    check_eq("stream_drained", {28'd0, inflight}, 32'd0);

    // Reset mid-operation with 7 tokens in flight
    for (int k = 0; k < 50; k++) begin
      if (sb_q.size() == 7) break;
      cycle(1'b1, 32'h300 + k, 1'b0);
    end
    check_eq("pre_reset_inflight", {28'd0, inflight}, 32'd7);
    in_start = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_out_start", {31'd0, out_start}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("midrst_inflight", {28'd0, inflight}, 32'd0);
    check_eq("midrst_out_args", out_args, 32'd0);
    check_eq("midrst_grace", {31'd0, grace_busy}, 32'd1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    gm = G;
    for (int k = 0; k < 20; k++) cycle(1'b0, 32'h0, 1'b1);
    check_eq("post_rst_out_start", {31'd0, out_start}, 32'd0);
    check_eq("post_rst_inflight", {28'd0, inflight}, 32'd0);

    // LEVEL=1, GRACE_PERIOD=0 instance
    reset1 = 1'b1;
    @(negedge clk);
    check_eq("l1_grace", {31'd0, s_grace}, 32'd0);
    check_eq("l1_in_ready", {31'd0, s_in_ready}, 32'd1);
    s_start = 1'b1; s_args = 8'h3C; s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check_eq("l1_lat_start", {31'd0, s_out_start}, 32'd1);
    check_eq("l1_lat_args", {24'd0, s_out_args}, 32'h3C);
    check_eq("l1_lat_inflight", {30'd0, s_inflight}, 32'd1);
    @(negedge clk);
    check_eq("l1_empty", {30'd0, s_inflight}, 32'd0);
    s_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      s_start = 1'b1;
      s_args = 8'h50 + 8'(k);
      #1;
      if (s_start && s_in_ready) acc++;
      @(negedge clk);
    end
    s_start = 1'b0;
    check_eq("l1_cap_accepts", acc, 32'd2);
    check_eq("l1_cap_inflight", {30'd0, s_inflight}, 32'd2);
    check_eq("l1_cap_in_ready", {31'd0, s_in_ready}, 32'd0);
    check_eq("l1_cap_head", {24'd0, s_out_args}, 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
